// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and types for the register file and scoreboard
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy bits, issue acceptance and per-port hazard flags
// Optional same-cycle release bypass on HAZ: REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     a3,
  input  logic              issue,
  input  logic [AW-1:0]     issue_rd,
  input  logic [NRD*AW-1:0] ra,
  output logic              issue_rdy,
  output logic [NRD-1:0]    haz
);
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [NREG-1:0] busy_q, busy_d;

  // A producer retiring this cycle frees its slot for the next producer immediately.
  always_comb begin
    issue_rdy = !busy_q[issue_rd] || (we && (a3 == issue_rd));
  end

  // Set is applied after clear so a same-register re-issue keeps the bit high.
  always_comb begin
    busy_d = busy_q;
    if (we && (a3 != ZR)) busy_d[a3] = 1'b0;
    if (issue && issue_rdy && (issue_rd != ZR)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    haz = '0;
    for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_BYPASS_EN
      haz[i] = busy_q[ra[i*AW +: AW]] && !(we && (a3 == ra[i*AW +: AW]));
`else
      haz[i] = busy_q[ra[i*AW +: AW]];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with registered read ports, LED tap and write-back scoreboard
// Optional write-to-read bypass on the read ports: REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = 2,
  parameter int LED_REG = 2,
  parameter int LED_W   = 8,
  parameter int AW      = $clog2(NREG)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RE,
  input  logic [NRD*AW-1:0]   RA,
  output logic [NRD*XLEN-1:0] RD,
  output logic [NRD-1:0]      HAZ,
  input  logic                WE,
  input  logic [AW-1:0]       A3,
  input  logic [XLEN-1:0]     WB,
  input  logic                ISSUE,
  input  logic [AW-1:0]       ISSUE_RD,
  output logic                ISSUE_RDY,
  output logic [LED_W-1:0]    LED
);
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [NRD*XLEN-1:0] rd_q, rd_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (WE && (A3 != ZR)) begin
      regs_q[A3] <= WB;
    end
  end

  always_comb begin
    rd_d = rd_q;
    if (RE) begin
      for (int i = 0; i < NRD; i++) begin
        if (RA[i*AW +: AW] == ZR) rd_d[i*XLEN +: XLEN] = '0;
`ifdef REGFILE_BYPASS_EN
        else if (WE && (A3 == RA[i*AW +: AW])) rd_d[i*XLEN +: XLEN] = WB;
`endif
        else rd_d[i*XLEN +: XLEN] = regs_q[RA[i*AW +: AW]];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign RD  = rd_q;
  assign LED = regs_q[LED_REG][LED_W-1:0];

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .AW   (AW)
  ) u_sb (
    .clk       (CLK),
    .rst       (RST),
    .we        (WE),
    .a3        (A3),
    .issue     (ISSUE),
    .issue_rd  (ISSUE_RD),
    .ra        (RA),
    .issue_rdy (ISSUE_RDY),
    .haz       (HAZ)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized bench for regfile_sb against a behavioural model
module tb_regfile_sb;
  localparam int XLEN = 32, NREG = 16, NRD = 3, LED_REG = 2, LED_W = 8;
  localparam int AW = $clog2(NREG);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RST, RE, WE, ISSUE;
  logic [NRD*AW-1:0]   RA;
  logic [NRD*XLEN-1:0] RD;
  logic [NRD-1:0]      HAZ;
  logic [AW-1:0]       A3, ISSUE_RD;
  logic [XLEN-1:0]     WB;
  logic                ISSUE_RDY;
  logic [LED_W-1:0]    LED;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .LED_REG(LED_REG), .LED_W(LED_W)) dut (
    .CLK(CLK), .RST(RST), .RE(RE), .RA(RA), .RD(RD), .HAZ(HAZ), .WE(WE), .A3(A3), .WB(WB),
    .ISSUE(ISSUE), .ISSUE_RD(ISSUE_RD), .ISSUE_RDY(ISSUE_RDY), .LED(LED)
  );

  always #5 CLK = ~CLK;

  int unsigned m_regs [NREG];
  bit          m_busy [NREG];
  int unsigned m_rd   [NRD];
  bit          m_valid = 1'b0;
  int          n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int ra_of(input int i);
    return int'(RA[i*AW +: AW]);
  endfunction

  function automatic bit m_rdy();
    return !m_busy[ISSUE_RD] || (WE && A3 == ISSUE_RD);
  endfunction

  // Compare all outputs against the model, then advance the model by one edge.
  task automatic model_cycle();
    bit rdy;
    if (m_valid) begin
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("rd%0d", i), RD[i*XLEN +: XLEN], m_rd[i]);
        chk($sformatf("haz%0d", i), HAZ[i],
            m_busy[ra_of(i)] && !(BYP && WE && A3 == ra_of(i)));
      end
      chk("issue_rdy", ISSUE_RDY, m_rdy());
      chk("led", LED, m_regs[LED_REG] % 256);
    end
    rdy = m_rdy();
    if (RST) begin
      for (int r = 0; r < NREG; r++) begin m_regs[r] = 0; m_busy[r] = 0; end
      for (int i = 0; i < NRD; i++) m_rd[i] = 0;
      m_valid = 1'b1;
    end else begin
      if (RE)
        for (int i = 0; i < NRD; i++) begin
          if (ra_of(i) == 0) m_rd[i] = 0;
          else if (BYP && WE && A3 == ra_of(i)) m_rd[i] = WB;
          else m_rd[i] = m_regs[ra_of(i)];
        end
      if (WE && A3 != 0) begin m_regs[A3] = WB; m_busy[A3] = 0; end
      if (ISSUE && rdy && ISSUE_RD != 0) m_busy[ISSUE_RD] = 1;
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    model_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 0; RE = 0; WE = 0; ISSUE = 0; RA = '0; A3 = '0; WB = '0; ISSUE_RD = '0;
  endtask

  task automatic set_ra(input int i, input int a);
    RA[i*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    idle(); WE = 1; A3 = AW'(a); WB = d; cyc();
  endtask

  initial begin
    idle(); RST = 1; cyc(); cyc();
    idle(); #1;
    chk("reset_rd", RD, '0);
    chk("reset_haz", HAZ, '0);
    chk("reset_rdy", ISSUE_RDY, 1'b1);
    chk("reset_led", LED, '0);

    wr(0, 32'hDEADBEEF);
    idle(); RE = 1; set_ra(0, 0); cyc();
    chk("r0_zero", RD[0 +: XLEN], 32'h0);

    idle(); WE = 1; A3 = 7; WB = 32'hA5A5A5A5; RE = 1; set_ra(1, 7); cyc();
    chk("bypass_rd1", RD[XLEN +: XLEN], BYP ? 32'hA5A5A5A5 : 32'h0);

    idle(); ISSUE = 1; ISSUE_RD = 9; cyc();
    idle(); set_ra(0, 9); ISSUE_RD = 9; #1;
    chk("haz_after_issue", HAZ[0], 1'b1);
    chk("rdy_waw_stall", ISSUE_RDY, 1'b0);
    cyc();
    WE = 1; A3 = 9; WB = 32'h99; ISSUE = 1; #1;
    chk("rdy_release_cycle", ISSUE_RDY, 1'b1);
    cyc();
    idle(); set_ra(0, 9); #1;
    chk("busy_set_wins", HAZ[0], 1'b1);
    wr(9, 32'h1);

    wr(LED_REG, 32'h000001FF);
    idle(); #1;
    chk("led_ff", LED, 8'hFF);

    wr(1, 32'h11); wr(2, 32'h22); wr(15, 32'hFF);
    idle(); RE = 1; set_ra(0, 1); set_ra(1, 2); set_ra(2, 15); cyc();
    chk("rd_p0", RD[0 +: XLEN], 32'h11);
    chk("rd_p1", RD[XLEN +: XLEN], 32'h22);
    chk("rd_p2", RD[2*XLEN +: XLEN], 32'hFF);

    wr(5, 32'h1234);
    idle(); ISSUE = 1; ISSUE_RD = 5; cyc();
    idle(); RST = 1; WE = 1; A3 = 6; WB = 32'h77; ISSUE = 1; ISSUE_RD = 6; RE = 1; set_ra(0, 5); cyc();
    idle(); set_ra(0, 5); ISSUE_RD = 5; #1;
    chk("rst_mid_rd", RD, '0);
    chk("rst_mid_haz", HAZ, '0);
    chk("rst_mid_rdy", ISSUE_RDY, 1'b1);
    chk("rst_mid_led", LED, '0);
    RE = 1; cyc();
    chk("rst_mid_read5", RD[0 +: XLEN], 32'h0);

    for (int n = 0; n < 3000; n++) begin
      RST = ($urandom_range(0, 199) == 0);
      RE = $urandom_range(0, 1) != 0;
      WE = $urandom_range(0, 1) != 0;
      ISSUE = $urandom_range(0, 1) != 0;
      A3 = AW'($urandom_range(0, NREG - 1));
      ISSUE_RD = AW'($urandom_range(0, NREG - 1));
      WB = $urandom;
      for (int i = 0; i < NRD; i++) set_ra(i, $urandom_range(0, NREG - 1));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with an integrated write-back scoreboard for the pipelined core. It sits between decode and write-back: decode reads operands through NRD registered read ports and reserves destination registers; write-back commits results and releases reservations. A hardwired-zero register 0 and an LED tap of one architectural register are kept from the previous generation.

## Interface
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, ≥ 4.
- NRD, 2, number of read ports (1–4).
- LED_REG, 2, index of the register driven onto LED.
- LED_W, 8, LED width, ≤ XLEN.
- Derived: AW = $clog2(NREG).

- CLK  in  1  single clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- RE  in  1  read strobe; capture all read ports this edge.
- RA  in  NRD*AW  packed read addresses, port i at [i*AW +: AW].
- RD  out  NRD*XLEN  packed registered read data.
- HAZ  out  NRD  per-port hazard: addressed register has a pending write.
- WE  in  1  write-back enable.
- A3  in  AW  write-back address.
- WB  in  XLEN  write-back data.
- ISSUE  in  1  request to reserve ISSUE_RD.
- ISSUE_RD  in  AW  destination to reserve.
- ISSUE_RDY  out  1  reservation can be accepted this cycle.
- LED  out  LED_W  regs[LED_REG][LED_W-1:0].

## Operation
- Reset (RST=1 at edge): all registers 0, RD 0, all busy bits 0; LED therefore 0, HAZ 0, ISSUE_RDY 1. Reset overrides every concurrent WE/ISSUE/RE.
- Write: WE=1 and A3≠0 → regs[A3] <= WB; busy[A3] <= 0. A3=0 ignored entirely; regs[0] always reads 0.
- Read: RE=1 → for each i, RD[i] <= (RA[i]==0) ? 0 : regs[RA[i]]. RE=0 → RD holds.
- Scoreboard: busy bit per register, busy[0] constantly 0. ISSUE=1 and ISSUE_RDY=1 and ISSUE_RD≠0 → busy[ISSUE_RD] <= 1. ISSUE with ISSUE_RD=0 accepted, no effect.
- ISSUE_RDY = !busy[ISSUE_RD] || (WE && A3==ISSUE_RD) — a second producer to an in-flight register (WAW) stalls until release, or is accepted in the release cycle.
- Simultaneous WE clear and accepted ISSUE set on same register: set wins, busy stays 1.
- HAZ[i] = busy[RA[i]], qualified as in Configuration. Combinational from RA, WE, A3 and state.
- ISSUE with ISSUE_RDY=0: ignored, no state change; requester must hold.

## Timing
- Read latency 1 cycle from RE edge to RD.
- Write visible to a read captured on the next edge; same-edge visibility only with bypass.
- Busy set visible on HAZ/ISSUE_RDY the cycle after acceptance; clear visible the cycle after WE (earlier only via bypass/ISSUE_RDY terms above).
- LED updates one cycle after a write to LED_REG.

## Configuration
- REGFILE_BYPASS_EN defined: on RE, if WE && A3≠0 && A3==RA[i], RD[i] <= WB; HAZ[i] also deasserted when WE && A3==RA[i].
- Undefined: RD[i] gets the pre-write value; HAZ[i] = busy[RA[i]] with no WE term; decode must wait one cycle.

## Structure
- Package regfile_pkg: default XLEN/NREG constants, reg_addr_t typedef (logic [AW-1:0]), zero-register constant.
- Sub-module regfile_scoreboard: busy vector, set/clear priority, ISSUE_RDY and HAZ generation; storage and read ports stay in regfile_sb.

## Test plan
- Reset mid-operation: busy[5]=1, regs[5]=0x1234, RST=1 one cycle → RD=0, HAZ=0, ISSUE_RDY=1, LED=0, read of 5 returns 0.
- Write 0xDEADBEEF to A3=0, then RE with RA[0]=0 → RD[0]=0.
- WE A3=7 WB=0xA5A5A5A5 and RE RA[1]=7 same edge → RD[1]=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value (0) without.
- ISSUE_RD=9 accepted; next cycle RA[0]=9 → HAZ[0]=1, ISSUE_RD=9 → ISSUE_RDY=0; WE A3=9 → ISSUE_RDY=1 same cycle; accepted → busy[9] stays 1.
- Write 0x000001FF to LED_REG=2 → LED=0xFF one cycle later.
- NRD=3, NREG=16: three ports read regs 1,2,15 preloaded 0x11,0x22,0xFF → RD ports return them after one edge.
